// File: rtl/gf2_syndrome_decoder.sv
// Sequential GF(2) syndrome decoder: builds s = H*r one row per cycle, then scans the
// columns of H for a single-bit error pattern and returns the corrected word.
module gf2_syndrome_decoder #(
    parameter int unsigned N  = 7,
    parameter int unsigned R  = 3,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned RW = (R > 1) ? $clog2(R) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R*N-1:0]  H_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    cw_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    data_out,
    output logic [R-1:0]    syndrome_out,
    output logic [1:0]      status,
    output logic [PW-1:0]   err_pos
);

    typedef enum logic [1:0] {StIdle, StSynd, StSearch, StDone} state_e;

    localparam logic [1:0]    StatNoErr   = 2'b00;
    localparam logic [1:0]    StatCorr    = 2'b01;
    localparam logic [1:0]    StatUncorr  = 2'b10;
    localparam logic [RW-1:0] LastRow     = RW'(R - 1);
    localparam logic [PW-1:0] LastCol     = PW'(N - 1);
    localparam logic [N-1:0]  OneHot      = N'(1);

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   col_q, col_d;
    logic [N-1:0]    cw_q, cw_d;
    logic [R-1:0]    syn_q, syn_d;
    logic [1:0]      status_q, status_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [N-1:0]    row_vec;
    logic            syn_bit;
    logic [R-1:0]    syn_full;
    logic [R-1:0]    h_col;

    // Current parity-check row and the syndrome including the bit produced this cycle.
    always_comb begin
        row_vec  = H_in[N*row_q +: N];
        syn_bit  = ^(row_vec & cw_q);
        syn_full = syn_q;
        syn_full[row_q] = syn_bit;
    end

    // Column col_q of H, gathered across all rows.
    always_comb begin
        h_col = '0;
        for (int unsigned r = 0; r < R; r++) begin
            h_col[r] = H_in[N*r + col_q];
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        cw_d     = cw_q;
        syn_d    = syn_q;
        status_d = status_q;
        pos_d    = pos_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    cw_d     = cw_in;
                    syn_d    = '0;
                    row_d    = '0;
                    col_d    = '0;
                    status_d = StatNoErr;
                    pos_d    = '0;
                    state_d  = StSynd;
                end
            end
            StSynd: begin
                syn_d = syn_full;
                if (row_q == LastRow) begin
                    if (syn_full == '0) begin
                        status_d = StatNoErr;
                        state_d  = StDone;
                    end else begin
                        col_d   = '0;
                        state_d = StSearch;
                    end
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            StSearch: begin
                // syn_q is nonzero here, so an all-zero column can never match.
                if (h_col == syn_q) begin
                    cw_d     = cw_q ^ (OneHot << col_q);
                    status_d = StatCorr;
                    pos_d    = col_q;
                    state_d  = StDone;
                end else if (col_q == LastCol) begin
                    status_d = StatUncorr;
                    state_d  = StDone;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake flags track the next state so they come straight out of flops.
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            cw_q        <= '0;
            syn_q       <= '0;
            status_q    <= StatNoErr;
            pos_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cw_q        <= cw_d;
            syn_q       <= syn_d;
            status_q    <= status_d;
            pos_q       <= pos_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign data_out     = cw_q;
    assign syndrome_out = syn_q;
    assign status       = status_q;
    assign err_pos      = pos_q;

endmodule

// File: doc/gf2_syndrome_decoder.md
# gf2_syndrome_decoder

Sequential GF(2) syndrome decoder that pairs with the combinational GF(2) matrix multiplier used for encoding. It accepts an N-bit received codeword and computes the syndrome s = H·r over GF(2), one parity-check row per cycle. It then searches the columns of H for a single-bit error, corrects it, and returns the corrected word with a status code. It sits on the receive path behind a valid/ready handshake on both sides.

## Interface
- N, default 7: codeword length in bits.
- R, default 3: number of parity-check rows (syndrome width). K = N−R is informational only.
- clk  input  1: single clock, rising edge.
- rst  input  1: asynchronous, active-low reset.
- H_in  input  R*N: parity-check matrix, row-major. Row r is H_in[N*r +: N]; bit j of a row is column j.
- in_valid  input  1: codeword on cw_in is valid.
- in_ready  output  1: block accepts a codeword.
- cw_in  input  N: received codeword. Bit j pairs with column j of H.
- out_valid  output  1: result valid.
- out_ready  input  1: consumer accepts result.
- data_out  output  N: corrected codeword.
- syndrome_out  output  R: computed syndrome. Bit r = XOR over j of (H[r][j] AND cw[j]).
- status  output  2: 2'b00 no error, 2'b01 single error corrected, 2'b10 uncorrectable, 2'b11 never produced.
- err_pos  output  ceil(log2 N): corrected bit index when status = 01, otherwise 0.

## Operation
- States: IDLE, SYND, SEARCH, DONE. Row counter 0..R−1; column counter 0..N−1.
- IDLE
  - in_ready = 1.
  - On in_valid && in_ready: register cw_in, clear the syndrome register and row counter, go to SYND.
- SYND
  - Each cycle, syndrome[row] <= ^(H[row] & cw_reg), then row++.
  - At row = R−1, including the bit being written that cycle:
    - Full syndrome is zero: go to DONE, status 00.
    - Otherwise: column counter = 0, go to SEARCH.
- SEARCH
  - Each cycle, compare column col (the bits H[r][col] for r = 0..R−1) with the syndrome.
  - Match: flip cw_reg[col], set status 01 and err_pos = col, go to DONE.
  - The lowest matching index wins when columns repeat.
  - No match at col = N−1: status 10, cw_reg unchanged, go to DONE.
  - A zero column never matches, because the syndrome is nonzero here.
- DONE
  - out_valid = 1; data_out = cw_reg.
  - On out_ready: go to IDLE.
- Output behaviour:
  - data_out, syndrome_out, status and err_pos are registered.
  - They hold their values until the next codeword is accepted.
  - They are stable throughout DONE under backpressure.
- Double errors whose syndrome equals some column are miscorrected by design. This is standard SEC behaviour and is not flagged.
- H_in must be stable from acceptance until the output handshake. Changing it mid-operation gives an unspecified result.
- in_valid is ignored outside IDLE; only one codeword is in flight.

## Timing
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - in_ready = 0, out_valid = 0, data_out = 0, syndrome_out = 0, status = 00, err_pos = 0.
  - in_ready rises at the first clk edge after rst deasserts.
- Latency is counted in edges from the accept edge to out_valid high:
  - Zero syndrome: R.
  - Corrected error at column j: R+1+j.
  - Uncorrectable: R+N.
- out_valid falls, and in_ready rises, on the edge after the out_valid && out_ready handshake. No bypass: the next accept is at least one cycle later.
- Reset asserted in any state aborts immediately. No partial result is ever presented.

## Test plan
- Zero syndrome. Hamming H with N=7, R=3, column j = binary (j+1); cw_in = 7'b0000000.
  - Required: syndrome_out 000, status 00, data_out 0.
  - out_valid high 3 edges after the accept edge.
- Single error. Same H; cw_in = 7'b0010000.
  - Required: syndrome_out 3'b101, status 01, err_pos 4, data_out 7'b0000000.
  - Latency 8.
- Double error, miscorrected. Same H; cw_in = 7'b0000011.
  - Required: syndrome_out 3'b011, status 01, err_pos 2, data_out 7'b0000111.
- Uncorrectable. N=6, R=3, columns = binary 1..6; cw_in = 6'b100001.
  - Required: syndrome_out 3'b111, status 10, data_out 6'b100001.
  - Latency 9.
- Backpressure. Hold out_ready low for 5 cycles in DONE while toggling in_valid.
  - Required: outputs stable, in_ready = 0, no capture.
  - After release: in_ready high the next cycle, back-to-back second word decodes correctly.
- Reset mid-SEARCH. Pull rst low during the single-error case above.
  - Required: all outputs zero at once.
  - After release, a fresh 7'b0000001 yields err_pos 0, status 01.
